// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and data access.
// Data accesses take strict priority over fetches. Every bus access is bounded
// by a TIMEOUT-cycle watchdog that aborts it and flags bus_err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall[5:0], flush        pipeline stall vector (bit 1 holds IF/ID), flush
//   if_ce, if_addr           fetch request / address
//   if_inst, if_stallreq     fetched instruction, fetch-pending stall request
//   mem_ce, mem_we, mem_addr, mem_wdata, mem_sel   data access request
//   mem_rdata, mem_stallreq  load data, data-pending stall request
//   bus_req, bus_we, bus_addr, bus_wdata, bus_sel  shared bus request
//   bus_ack, bus_rdata       bus completion and read data
//   bus_err                  one-cycle pulse when an access times out
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_stallreq,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        IF_BUSY    = 3'd1,
        IF_DONE    = 3'd2,
        MEM_BUSY   = 3'd3,
        MEM_DONE   = 3'd4,
        FLUSH_WAIT = 3'd5
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               bus_req_d, bus_we_d, bus_err_d;
    logic [31:0]        bus_addr_d, bus_wdata_d, if_inst_d, mem_rdata_d;
    logic [3:0]         bus_sel_d;
    logic               timeout, done;
    logic [31:0]        rdata;

    // Only stall[1] (IF/ID hold) matters here.
    logic unused_stall;
    assign unused_stall = ^{stall[5:2], stall[0]};

    // An access ends on ack or watchdog expiry; an expired access reads as zero.
    assign timeout = (cnt == CNT_W'(TIMEOUT));
    assign done    = bus_ack | timeout;
    assign rdata   = bus_ack ? bus_rdata : 32'h0;

    // Stall requests are combinational so the pipeline freezes in the same cycle.
    assign mem_stallreq = mem_ce && (state != MEM_DONE);
    assign if_stallreq  = (if_ce && (state != IF_DONE)) || (state == FLUSH_WAIT);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_err   <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_sel   <= 4'h0;
            if_inst   <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_err   <= bus_err_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            bus_sel   <= bus_sel_d;
            if_inst   <= if_inst_d;
            mem_rdata <= mem_rdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bus_req_d   = bus_req;
        bus_we_d    = bus_we;
        bus_err_d   = 1'b0;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        bus_sel_d   = bus_sel;
        if_inst_d   = if_inst;
        mem_rdata_d = mem_rdata;

        case (state)
            IDLE: begin
                if (mem_ce) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                    cnt_d       = '0;
                    state_d     = MEM_BUSY;
                end else if (if_ce && !flush) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = 32'h0;
                    bus_sel_d   = 4'hF;
                    cnt_d       = '0;
                    state_d     = IF_BUSY;
                end
            end

            // A committed data access ignores flush.
            MEM_BUSY: begin
                if (done) begin
                    bus_req_d   = 1'b0;
                    bus_err_d   = !bus_ack;
                    mem_rdata_d = rdata;
                    state_d     = MEM_DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            MEM_DONE: state_d = IDLE;

            // A flush arriving with the completion discards the instruction.
            IF_BUSY: begin
                if (done) begin
                    bus_req_d = 1'b0;
                    bus_err_d = !bus_ack;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        if_inst_d = rdata;
                        state_d   = IF_DONE;
                    end
                end else if (flush) begin
                    cnt_d   = '0;
                    state_d = FLUSH_WAIT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            IF_DONE: begin
                if (!stall[1] || flush) state_d = IDLE;
            end

            // Let the outstanding fetch finish on the bus, then drop its data.
            FLUSH_WAIT: begin
                if (done) begin
                    bus_req_d = 1'b0;
                    bus_err_d = !bus_ack;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles a bus access may wait for bus_ack before being aborted.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 stall  in  6  pipeline stall vector; bit 1 high = IF/ID register held.
REQ-005 flush  in  1  pipeline flush (branch/exception); discards pending fetch result.
REQ-006 if_ce  in  1  fetch request from PC stage.
REQ-007 if_addr  in  32  fetch address (pc).
REQ-008 if_inst  out  32  fetched instruction, valid while in IF_DONE.
REQ-009 if_stallreq  out  1  fetch not yet complete; requests pipeline stall.
REQ-010 mem_ce, mem_we  in  1 each  data access request / write enable from MEM stage.
REQ-011 mem_addr, mem_wdata  in  32 each  data address / write data.
REQ-012 mem_sel  in  4  byte lane select.
REQ-013 mem_rdata  out  32  load data, valid while in MEM_DONE.
REQ-014 mem_stallreq  out  1  data access not yet complete; requests pipeline stall.
REQ-015 bus_req, bus_we  out  1 each  shared memory port request / write.
REQ-016 bus_addr, bus_wdata  out  32 each; bus_sel  out  4.
REQ-017 bus_ack  in  1; bus_rdata  in  32  memory completion and read data.
REQ-018 bus_err  out  1  one-cycle pulse when an access times out.

Function
REQ-019 The block SHALL implement a registered FSM with states IDLE, IF_BUSY, IF_DONE, MEM_BUSY, MEM_DONE and FLUSH_WAIT.
REQ-020 In IDLE, when mem_ce=1, the block SHALL latch mem_addr/mem_we/mem_sel/mem_wdata onto bus_*, assert bus_req next cycle, and go to MEM_BUSY.
REQ-021 In IDLE, when mem_ce=0 and if_ce=1 and flush=0, the block SHALL drive bus_addr=if_addr, bus_we=0, bus_sel=4'hF, assert bus_req, and go to IF_BUSY.
REQ-022 Data access SHALL have strict priority over fetch when both request in the same IDLE cycle.
REQ-023 bus_req and all bus_* outputs SHALL remain stable from assertion until the cycle bus_ack=1 is sampled, then bus_req SHALL drop on the next edge.
REQ-024 On bus_ack in MEM_BUSY, the block SHALL register bus_rdata into mem_rdata and go to MEM_DONE; MEM_DONE SHALL last exactly one cycle, then return to IDLE.
REQ-025 On bus_ack in IF_BUSY, the block SHALL register bus_rdata into if_inst and go to IF_DONE.
REQ-026 IF_DONE SHALL be held, with if_inst unchanged, while stall[1]=1; it SHALL exit to IDLE on the first cycle with stall[1]=0 or flush=1.
REQ-027 mem_stallreq SHALL be combinational: 1 when mem_ce=1 and state!=MEM_DONE, else 0.
REQ-028 if_stallreq SHALL be combinational: 1 when if_ce=1 and state is not IF_DONE, else 0; it SHALL also be 1 in FLUSH_WAIT.
REQ-029 flush=1 in IF_BUSY SHALL move the FSM to FLUSH_WAIT; on bus_ack there, the returned data SHALL be discarded and the FSM SHALL go to IDLE.
REQ-030 flush SHALL NOT abort MEM_BUSY or MEM_DONE; a committed data access always completes.
REQ-031 A cycle counter SHALL clear on entry to any BUSY or FLUSH_WAIT state and increment each cycle without bus_ack; at count==TIMEOUT the block SHALL drop bus_req, pulse bus_err for one cycle, load 32'h0 as the read result, and take the same transition as a bus_ack.
REQ-032 bus_ack while in IDLE, IF_DONE or MEM_DONE SHALL be ignored.

Reset
REQ-033 While rst=1 the FSM SHALL enter IDLE and the counter SHALL clear; bus_req, bus_we, bus_err, bus_addr, bus_wdata, bus_sel, if_inst and mem_rdata SHALL all be 0.
REQ-034 rst asserted mid-access SHALL abandon the access without waiting for bus_ack.

Verification
REQ-035 Fetch: if_ce=1, if_addr=0x04, ack after 2 cycles with 0x3C010001 -> if_inst=0x3C010001 in IF_DONE, if_stallreq low that cycle.
REQ-036 Collision: if_ce=1 and mem_ce=1 (load 0x100) in IDLE -> bus_addr=0x100 first, fetch issued only after MEM_DONE; if_stallreq high throughout.
REQ-037 Hold: fetch completes while stall[1]=1 for 3 cycles -> IF_DONE held 3 cycles, if_inst stable, no new bus_req.
REQ-038 Flush: flush=1 during IF_BUSY -> FLUSH_WAIT, data returned on ack discarded, if_inst unchanged, next fetch uses new if_addr.
REQ-039 Timeout: TIMEOUT=4, no bus_ack on load -> bus_req drops, bus_err high exactly one cycle, mem_rdata=0, mem_stallreq released.
REQ-040 Reset mid-store: rst=1 during MEM_BUSY -> next edge all outputs 0, state IDLE.
